// File: rtl/oric_tap_player.sv
// Oric .TAP player: buffers a downloaded tape image and replays it as the Oric cassette bit stream.
// Optional ORIC_TAP_MOTOR_EN: the VIA motor relay (motor = 0) also holds playback like pause.
module oric_tap_player #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned HALF_CYC  = 5000,
  parameter int unsigned STOP_BITS = 3
) (
  input  logic              clk_sys,
  input  logic              I_RESET,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              play,
  input  logic              pause,
  input  logic              rewind,
  input  logic              slow,
  input  logic              motor,
  output logic              tape_out,
  output logic              active,
  output logic              overflow,
  output logic [ADDR_W:0]   length
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = $clog2(2 * HALF_CYC);
  localparam logic [CntW-1:0] HalfM1   = CntW'(HALF_CYC - 1);
  localparam logic [CntW-1:0] FullM1   = CntW'(2 * HALF_CYC - 1);
  localparam logic [2:0]      StopLast = 3'(STOP_BITS - 1);
  localparam logic [ADDR_W:0] PtrOne   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StIdle, StFetch, StWait, StStart, StData, StParity, StStop, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d, length_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              phase_q, phase_d;   // 0: high half of a cycle, 1: low half
  logic [2:0]        rep_q, rep_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        byte_q, rd_data;
  logic              slow_q, load;
  logic              overflow_q;
  logic              play_q, rew_q, dl_q;
  logic              play_rise, rew_rise, dl_rise;
  logic              hold, in_range, wr_ok, wr_bad;
  logic [ADDR_W:0]   wr_len, ptr_inc;
  logic              cur_bit, in_bit, phase_end, bit_end;
  logic [CntW-1:0]   phase_m1;
  logic [2:0]        rep_last;
  logic [7:0]        mem [Depth];

`ifdef ORIC_TAP_MOTOR_EN
  assign hold = pause | ~motor;
`else
  logic unused_motor;
  assign unused_motor = motor;
  assign hold         = pause;
`endif

  assign play_rise = play & ~play_q;
  assign rew_rise  = rewind & ~rew_q;
  assign dl_rise   = ioctl_download & ~dl_q;

  assign in_range = (ioctl_addr >> ADDR_W) == 25'd0;
  assign wr_ok    = ioctl_download & ioctl_wr & in_range;
  assign wr_bad   = ioctl_download & ioctl_wr & ~in_range;
  assign wr_len   = {1'b0, ioctl_addr[ADDR_W-1:0]} + PtrOne;
  assign ptr_inc  = ptr_q + PtrOne;

  always_ff @(posedge clk_sys) begin
    if (wr_ok) mem[ioctl_addr[ADDR_W-1:0]] <= ioctl_dout;
    rd_data <= mem[ptr_q[ADDR_W-1:0]];
  end

  always_ff @(posedge clk_sys or negedge I_RESET) begin
    if (!I_RESET) begin
      length_q   <= '0;
      overflow_q <= 1'b0;
    end else if (dl_rise) begin
      // A write in the same cycle as the new download still counts.
      length_q   <= wr_ok ? wr_len : '0;
      overflow_q <= wr_bad;
    end else begin
      if (wr_ok && wr_len > length_q) length_q <= wr_len;
      if (wr_bad) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    unique case (state_q)
      StData:   cur_bit = byte_q[idx_q];
      StParity: cur_bit = ~^byte_q;
      StStop:   cur_bit = 1'b1;
      default:  cur_bit = 1'b0;
    endcase
  end

  assign in_bit   = (state_q == StStart) || (state_q == StData) ||
                    (state_q == StParity) || (state_q == StStop);
  assign phase_m1 = phase_q ? (cur_bit ? HalfM1 : FullM1)
                            : ((slow_q && !cur_bit) ? FullM1 : HalfM1);
  assign rep_last  = slow_q ? (cur_bit ? 3'd7 : 3'd3) : 3'd0;
  assign phase_end = (cnt_q == phase_m1);
  assign bit_end   = phase_end && phase_q && (rep_q == rep_last);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    load    = 1'b0;
    if (dl_rise || rew_rise) begin
      state_d = StIdle;
      ptr_d   = '0;
      cnt_d   = '0;
      phase_d = 1'b0;
      rep_d   = '0;
      idx_d   = '0;
    end else if (play_rise && (state_q == StIdle || state_q == StDone)) begin
      if (length_q != '0 && !ioctl_download) begin
        state_d = StFetch;
        if (state_q == StDone) ptr_d = '0;
      end
    end else if (!hold) begin
      unique case (state_q)
        StFetch: state_d = StWait;
        StWait: begin
          state_d = StStart;
          load    = 1'b1;
        end
        StStart, StData, StParity, StStop: begin
          if (bit_end) begin
            cnt_d   = '0;
            phase_d = 1'b0;
            rep_d   = '0;
            if (state_q == StStart) begin
              state_d = StData;
              idx_d   = '0;
            end else if (state_q == StData) begin
              idx_d = idx_q + 3'd1;
              if (idx_q == 3'd7) begin
                state_d = StParity;
                idx_d   = '0;
              end
            end else if (state_q == StParity) begin
              state_d = StStop;
              idx_d   = '0;
            end else if (idx_q == StopLast) begin
              idx_d   = '0;
              ptr_d   = ptr_inc;
              state_d = (ptr_inc == length_q) ? StDone : StFetch;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else if (phase_end) begin
            cnt_d = '0;
            if (phase_q) begin
              phase_d = 1'b0;
              rep_d   = rep_q + 3'd1;
            end else begin
              phase_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge I_RESET) begin
    if (!I_RESET) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      rep_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      slow_q  <= 1'b0;
      play_q  <= 1'b0;
      rew_q   <= 1'b0;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      play_q  <= play;
      rew_q   <= rewind;
      dl_q    <= ioctl_download;
      if (load) begin
        byte_q <= rd_data;
        slow_q <= slow;
      end
    end
  end

  assign tape_out = in_bit & ~phase_q;
  assign active   = (state_q != StIdle) && (state_q != StDone);
  assign overflow = overflow_q;
  assign length   = length_q;

endmodule
